// File: rtl/seq_add_sub_if.sv
// Operand/result bundle for the chunked signed adder/subtractor.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds its data stable while valid is high and ready is low.
interface seq_add_sub_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  overflow;

    modport master (
        output in_valid, A, B, sub, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, A, B, sub, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/seq_add_sub.sv
// Multi-cycle signed adder/subtractor: CHUNK_WIDTH bits per BUSY cycle with a registered
// carry between chunks; optional saturation on signed overflow.
module seq_add_sub #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHUNK_WIDTH = 4,
    parameter int SATURATE    = 0
) (
    input  logic            clk,
    input  logic            rst,
    seq_add_sub_if.slave    bus,
    output logic [1:0]      dbg_state
);
    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q;
    logic                   carry_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  beff_q;
    logic [DATA_WIDTH-1:0]  result_q;
    logic                   ovf_q;

    logic                   accept;
    logic                   last_chunk;
    logic [CHUNK_WIDTH-1:0] a_chunk;
    logic [CHUNK_WIDTH-1:0] b_chunk;
    logic [CHUNK_WIDTH:0]   chunk_sum;
    logic                   ovf_last;

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_chunk = (idx_q == IW'(NCHUNK - 1));

    always_comb begin
        a_chunk   = a_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_chunk   = beff_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};
        // Carry into the MSB is recovered from the MSB sum bit; only meaningful on the last chunk.
        ovf_last  = (a_chunk[CHUNK_WIDTH-1] ^ b_chunk[CHUNK_WIDTH-1] ^ chunk_sum[CHUNK_WIDTH-1])
                    ^ chunk_sum[CHUNK_WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last_chunk) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            beff_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.A;
                beff_q  <= bus.sub ? ~bus.B : bus.B;
                carry_q <= bus.sub;
                idx_q   <= '0;
            end else if (state_q == BUSY) begin
                result_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] <= chunk_sum[CHUNK_WIDTH-1:0];
                carry_q <= chunk_sum[CHUNK_WIDTH];
                idx_q   <= last_chunk ? '0 : idx_q + IW'(1);
                if (last_chunk) begin
                    ovf_q <= ovf_last;
                    // Later assignment overrides the chunk write above when clamping.
                    if (SATURATE != 0 && ovf_last)
                        result_q <= a_q[DATA_WIDTH-1] ? MIN_NEG : MAX_POS;
                end
            end
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign dbg_state    = state_q;
endmodule
